dmem_lsu: RTL and testbench

- Load/store unit directly upstream of the data memory; sole driver of its addr, write_data, mem_read, mem_write and stall inputs.
- Accepts one byte-addressed load/store request at a time from the EX/MEM pipeline register.
- Converts each request to word-indexed memory accesses. Sub-word stores use read-modify-write, because the memory has no byte enables.
- Returns aligned, sign- or zero-extended load data, or a store completion, to writeback over a valid/ready handshake.

---
 rtl/dmem_lsu_pkg.sv | 30 +++
 rtl/dmem_lsu_lane.sv | 49 ++++
 rtl/dmem_lsu.sv | 123 ++++++++++++
 tb/tb_dmem_lsu.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: size codes,
// FSM state encoding and the alignment check.
package dmem_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef logic [2:0] state_t;

  localparam state_t IDLE     = 3'd0;
  localparam state_t LD_RD    = 3'd1;
  localparam state_t LD_WAIT  = 3'd2;
  localparam state_t ST_WR    = 3'd3;
  localparam state_t RMW_RD   = 3'd4;
  localparam state_t RMW_WAIT = 3'd5;
  localparam state_t RMW_WR   = 3'd6;
  localparam state_t RESP     = 3'd7;

  // Size code 3 is reserved and always reported as misaligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offset[0];
      SZ_WORD: return offset != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_lane.sv
// Little-endian lane logic: load extract/extend and sub-word store merge.
module dmem_lsu_lane
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      SZ_BYTE: load_data = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
      SZ_HALF: load_data = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    merged = old_word;
    if (size == SZ_BYTE) begin
      case (offset)
        2'd0:    merged[7:0]   = wdata[7:0];
        2'd1:    merged[15:8]  = wdata[7:0];
        2'd2:    merged[23:16] = wdata[7:0];
        default: merged[31:24] = wdata[7:0];
      endcase
    end else if (size == SZ_HALF) begin
      if (offset[1]) merged[31:16] = wdata[15:0];
      else           merged[15:0]  = wdata[15:0];
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of a word-addressed data memory without byte
// enables; sub-word stores are done as read-modify-write.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int WIDX_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_we,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_stall,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done
);

  state_t               state;
  logic                 store_q;
  logic [1:0]           size_q;
  logic                 uns_q;
  logic [WIDX_BITS+1:0] addr_q;
  logic [31:0]          wdata_q;
  logic [4:0]           rd_q;
  logic [31:0]          merge_q;
  logic [31:0]          load_data;
  logic [31:0]          merged;
  logic                 unused_addr_bits;

  // Address bits above the word index are dropped, so addresses wrap.
  assign unused_addr_bits = ^{req_addr[31:WIDX_BITS+2], store_q};

  dmem_lsu_lane u_lane (
    .rdata       (mem_rdata),
    .old_word    (merge_q),
    .wdata       (wdata_q),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rd    = rd_q;
  assign mem_read   = (state == LD_RD) || (state == RMW_RD);
  assign mem_write  = (state == ST_WR) || (state == RMW_WR);
  assign mem_stall  = 1'b0;
  assign mem_addr   = {{(32-WIDX_BITS){1'b0}}, addr_q[WIDX_BITS+1:2]};
  assign mem_wdata  = (state == RMW_WR) ? merged : wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      store_q   <= 1'b0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      merge_q   <= '0;
      resp_data <= '0;
      resp_we   <= 1'b0;
      resp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            store_q   <= req_store;
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            addr_q    <= req_addr[WIDX_BITS+1:0];
            wdata_q   <= req_wdata;
            rd_q      <= req_rd;
            resp_data <= '0;
            resp_we   <= 1'b0;
            resp_err  <= misaligned(req_size, req_addr[1:0]);
            if (misaligned(req_size, req_addr[1:0])) state <= RESP;
            else if (!req_store)                     state <= LD_RD;
            else if (req_size == SZ_WORD)            state <= ST_WR;
            else                                     state <= RMW_RD;
          end
        end
        LD_RD:   state <= LD_WAIT;
        LD_WAIT: begin
          if (mem_done) begin
            resp_data <= load_data;
            resp_we   <= 1'b1;
            state     <= RESP;
          end
        end
        ST_WR:    state <= RESP;
        RMW_RD:   state <= RMW_WAIT;
        RMW_WAIT: begin
          if (mem_done) begin
            merge_q <= mem_rdata;
            state   <= RMW_WR;
          end
        end
        RMW_WR:  state <= RESP;
        RESP:    if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural 256-word memory model.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_ready, resp_we, resp_err;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_stall, mem_done;

  logic [31:0] mem [256];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          both_cnt = 0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;

  int errors = 0;
  int checks = 0;
  int lat;
  int wr0, rd0;

  always #5 clk = ~clk;

  dmem_lsu #(.WIDX_BITS(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_we(resp_we), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_stall(mem_stall), .mem_rdata(mem_rdata),
    .mem_done(mem_done)
  );

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0BADF00D ^ i;
    mem_rdata = '0;
  end

  always @(posedge clk) begin
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
    if (mem_write) begin
      mem[mem_addr[7:0]] <= mem_wdata;
      wr_cnt     <= wr_cnt + 1;
      last_waddr <= mem_addr;
      last_wdata <= mem_wdata;
    end
    if (mem_read) begin
      mem_rdata <= mem[mem_addr[7:0]];
      rd_cnt    <= rd_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request, returns edges from acceptance to resp_valid (50 = timeout).
  task automatic run_req(input logic st, input logic [1:0] sz, input logic un,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd, output int n);
    int w;
    w = 0;
    while (!req_ready && w < 50) begin @(posedge clk); #1; w++; end
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
    req_addr = a; req_wdata = wd; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 50) begin @(posedge clk); #1; n++; end
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = '0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; req_rd = '0;
    resp_ready = 1'b0; mem_done = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_flags", {30'd0, resp_we, resp_err}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", {31'd0, req_ready}, 32'd1);

    // word store then word load
    wr0 = wr_cnt;
    run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 5'd3, lat);
    chk("sw_lat", lat, 2);
    chk("sw_wr_count", wr_cnt - wr0, 1);
    chk("sw_waddr", last_waddr, 32'd4);
    chk("sw_wdata", last_wdata, 32'hDEADBEEF);
    chk("sw_resp", {resp_data[29:0], resp_we, resp_err}, 32'd0);
    ack();
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd7, lat);
    chk("lw_lat", lat, 3);
    chk("lw_data", resp_data, 32'hDEADBEEF);
    chk("lw_we", {31'd0, resp_we}, 32'd1);
    chk("lw_rd", {27'd0, resp_rd}, 32'd7);
    ack();

    // byte store via read-modify-write
    wr0 = wr_cnt; rd0 = rd_cnt;
    run_req(1'b1, 2'd0, 1'b0, 32'h12, 32'h123456A5, 5'd1, lat);
    chk("sb_lat", lat, 4);
    chk("sb_rd_count", rd_cnt - rd0, 1);
    chk("sb_wr_count", wr_cnt - wr0, 1);
    chk("sb_wdata", last_wdata, 32'hDEA5BEEF);
    ack();
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd2, lat);
    chk("lw2_data", resp_data, 32'hDEA5BEEF);
    ack();

    // sub-word loads
    run_req(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 5'd4, lat);
    chk("lb_data", resp_data, 32'hFFFFFFA5);
    ack();
    run_req(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 5'd4, lat);
    chk("lbu_data", resp_data, 32'h000000A5);
    ack();
    run_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 5'd5, lat);
    chk("lh_data", resp_data, 32'hFFFFDEA5);
    ack();
    run_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 5'd5, lat);
    chk("lhu_data", resp_data, 32'h0000BEEF);
    ack();
    run_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 5'd6, lat);
    chk("lbu3_data", resp_data, 32'h000000DE);
    ack();
    run_req(1'b0, 2'd0, 1'b0, 32'h410, 32'h0, 5'd6, lat);
    chk("wrap_data", resp_data, 32'hFFFFFFEF);
    ack();

    // misaligned and reserved-size requests
    wr0 = wr_cnt; rd0 = rd_cnt;
    run_req(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 5'd8, lat);
    chk("mis_lh_lat", lat, 1);
    chk("mis_lh_err", {31'd0, resp_err}, 32'd1);
    chk("mis_lh_data", resp_data, 32'd0);
    chk("mis_lh_we", {31'd0, resp_we}, 32'd0);
    ack();
    run_req(1'b1, 2'd2, 1'b0, 32'h12, 32'hCAFEF00D, 5'd9, lat);
    chk("mis_sw_lat", lat, 1);
    chk("mis_sw_err", {31'd0, resp_err}, 32'd1);
    ack();
    run_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 5'd9, lat);
    chk("mis_sz3_err", {31'd0, resp_err}, 32'd1);
    ack();
    chk("mis_no_strobe", (wr_cnt - wr0) + (rd_cnt - rd0), 0);

    // memory wait states on a load
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_addr = 32'h10; req_rd = 5'd10;
    mem_done = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("wait_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    mem_done = 1'b1;
    @(posedge clk); #1;
    chk("wait_resp", {31'd0, resp_valid}, 32'd1);
    chk("wait_data", resp_data, 32'hDEA5BEEF);

    // response held under backpressure; a pending request waits
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_addr = 32'h12; req_rd = 5'd11;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_data", resp_data, 32'hDEA5BEEF);
      chk("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("hs_idle_valid", {31'd0, resp_valid}, 32'd0);
    chk("hs_idle_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("hs_next_valid", {31'd0, resp_valid}, 32'd1);
    chk("hs_next_err", {31'd0, resp_err}, 32'd1);
    chk("hs_next_rd", {27'd0, resp_rd}, 32'd11);
    ack();

    // reset during RMW_WAIT of a byte store
    wr0 = wr_cnt;
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'd0; req_addr = 32'h20;
    req_wdata = 32'h00000077; req_rd = 5'd12;
    mem_done = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("mrst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("mrst_valid", {31'd0, resp_valid}, 32'd0);
    chk("mrst_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    mem_done = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mrst_no_write", wr_cnt - wr0, 0);
    chk("mrst_mem", mem[8], 32'h0BADF005);
    run_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 5'd13, lat);
    chk("mrst_load", resp_data, 32'h0BADF005);
    ack();

    chk("never_both_strobes", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
